// File: rtl/exception_control_unit_pkg.sv
// Shared MIPS control definitions: opcodes, ALU op classes, PC-select codes,
// exception codes, the ID/EX control bundle and the exception FSM states.
package exception_control_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_ERET  = 6'd16;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_LOGIC  = 2'b11;

   localparam logic [1:0] PCSEL_SEQ     = 2'b00;
   localparam logic [1:0] PCSEL_HANDLER = 2'b01;
   localparam logic [1:0] PCSEL_EPC     = 2'b10;

   localparam logic [4:0]  EXC_RI       = 5'd10;
   localparam logic [4:0]  EXC_OV       = 5'd12;
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_0180;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_TRAP   = 2'b01,
      ST_RETURN = 2'b10
   } ecu_state_e;

   typedef struct packed {
      logic       reg_dst;
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = 9'b0_0000_0000;

endpackage

// File: rtl/exception_control_unit_main_decoder.sv
// Purely combinational opcode-to-control decode with invalid-instruction flag.
// ERET is only legal inside the handler (exl = 1).
module main_decoder
   import exception_control_unit_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       exl,
   output ctrl_t      ctrl,
   output logic       invalid,
   output logic       eret
);

   // Opcode to control-bundle decode
   always_comb begin
      ctrl    = CTRL_NOP;
      invalid = 1'b0;
      eret    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_RTYPE;
         end
         OP_BEQ, OP_BNE: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALUOP_SUB;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_op     = ALUOP_ADD;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
         end
         OP_ANDI, OP_ORI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_LOGIC;
         end
         OP_ERET: begin
            eret = 1'b1;
            if (exl) begin
               invalid = 1'b0;
            end else begin
               invalid = 1'b1;
            end
         end
         default: begin
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/exception_control_unit.sv
// Main pipeline control with precise-exception handling: ID/EX control register,
// bubble insertion, EPC/Cause capture, handler redirect and ERET return.
module exception_control_unit
   import exception_control_unit_pkg::*;
#(
   parameter int         PC_WIDTH = 32,
   parameter logic [4:0] CAUSE_RI = EXC_RI,
   parameter logic [4:0] CAUSE_OV = EXC_OV
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          opcode,
   input  logic [PC_WIDTH-1:0] id_pc,
   input  logic [PC_WIDTH-1:0] ex_pc,
   input  logic                overflow,
   input  logic                stall,
   output logic                ex_RegDst,
   output logic                ex_Branch,
   output logic                ex_MemRead,
   output logic                ex_MemtoReg,
   output logic                ex_MemWrite,
   output logic                ex_ALUSrc,
   output logic                ex_RegWrite,
   output logic [1:0]          ex_ALUOp,
   output logic [1:0]          pc_sel,
   output logic                if_flush,
   output logic                id_flush,
   output logic                ex_flush,
   output logic [PC_WIDTH-1:0] epc,
   output logic [4:0]          cause,
   output logic                exl,
   output logic                double_fault
);

   ctrl_t               dec_ctrl_s;
   ctrl_t               idex_r;
   logic                invalid_s;
   logic                eret_s;
   ecu_state_e          state_r;
   ecu_state_e          next_state_s;
   logic                exc_s;
   logic                take_s;
   logic                dfault_s;
   logic [1:0]          pc_sel_r;
   logic                if_flush_r;
   logic                id_flush_r;
   logic [PC_WIDTH-1:0] epc_r;
   logic [4:0]          cause_r;
   logic                exl_r;
   logic                double_fault_r;

   main_decoder u_main_decoder (
      .opcode  (opcode),
      .exl     (exl_r),
      .ctrl    (dec_ctrl_s),
      .invalid (invalid_s),
      .eret    (eret_s)
   );

   // Exceptions are only recognised in IDLE; TRAP/RETURN cycles carry wrong-path work
   always_comb begin
      exc_s = 1'b0;
      if (state_r == ST_IDLE) begin
         exc_s = overflow | invalid_s;
      end else begin
         exc_s = 1'b0;
      end
      take_s   = exc_s & ~exl_r;
      dfault_s = exc_s & exl_r;
   end

   // Exception FSM next-state
   always_comb begin
      next_state_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (take_s) begin
               next_state_s = ST_TRAP;
            end else if (eret_s && exl_r && !exc_s) begin
               next_state_s = ST_RETURN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_TRAP:   next_state_s = ST_IDLE;
         ST_RETURN: next_state_s = ST_IDLE;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // Exception FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // ID/EX control register; an exception beats a stall but both yield a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         idex_r <= CTRL_NOP;
      end else if ((state_r != ST_IDLE) || exc_s) begin
         idex_r <= CTRL_NOP;
      end else if (stall) begin
         idex_r <= CTRL_NOP;
      end else begin
         idex_r <= dec_ctrl_s;
      end
   end

   // Redirect and flush, asserted for the single TRAP or RETURN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_sel_r   <= PCSEL_SEQ;
         if_flush_r <= 1'b0;
         id_flush_r <= 1'b0;
      end else begin
         case (next_state_s)
            ST_TRAP: begin
               pc_sel_r   <= PCSEL_HANDLER;
               if_flush_r <= 1'b1;
               id_flush_r <= 1'b1;
            end
            ST_RETURN: begin
               pc_sel_r   <= PCSEL_EPC;
               if_flush_r <= 1'b1;
               id_flush_r <= 1'b1;
            end
            default: begin
               pc_sel_r   <= PCSEL_SEQ;
               if_flush_r <= 1'b0;
               id_flush_r <= 1'b0;
            end
         endcase
      end
   end

   // EPC/Cause capture on a taken exception; EXL cleared as RETURN completes
   always_ff @(posedge clk) begin
      if (rst) begin
         epc_r          <= {PC_WIDTH{1'b0}};
         cause_r        <= 5'd0;
         exl_r          <= 1'b0;
         double_fault_r <= 1'b0;
      end else begin
         double_fault_r <= dfault_s;
         if (take_s) begin
            epc_r   <= overflow ? ex_pc : id_pc;
            cause_r <= overflow ? CAUSE_OV : CAUSE_RI;
            exl_r   <= 1'b1;
         end else if (state_r == ST_RETURN) begin
            exl_r <= 1'b0;
         end
      end
   end

   assign ex_RegDst    = idex_r.reg_dst;
   assign ex_Branch    = idex_r.branch;
   assign ex_MemRead   = idex_r.mem_read;
   assign ex_MemtoReg  = idex_r.mem_to_reg;
   assign ex_MemWrite  = idex_r.mem_write;
   assign ex_ALUSrc    = idex_r.alu_src;
   assign ex_RegWrite  = idex_r.reg_write;
   assign ex_ALUOp     = idex_r.alu_op;
   assign pc_sel       = pc_sel_r;
   assign if_flush     = if_flush_r;
   assign id_flush     = id_flush_r;
   assign ex_flush     = overflow;
   assign epc          = epc_r;
   assign cause        = cause_r;
   assign exl          = exl_r;
   assign double_fault = double_fault_r;

endmodule

// File: tb/tb_exception_control_unit.sv
// Directed scoreboard bench for exception_control_unit: expected output sets are
// queued as each step is driven and compared one cycle later.
module tb_exception_control_unit;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [31:0] id_pc;
   logic [31:0] ex_pc;
   logic        overflow;
   logic        stall;
   logic        ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg;
   logic        ex_MemWrite, ex_ALUSrc, ex_RegWrite;
   logic [1:0]  ex_ALUOp;
   logic [1:0]  pc_sel;
   logic        if_flush, id_flush, ex_flush;
   logic [31:0] epc;
   logic [4:0]  cause;
   logic        exl;
   logic        double_fault;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [8:0]  ctrl;
      logic [1:0]  pc_sel;
      logic        if_flush;
      logic        id_flush;
      logic        ex_flush;
      logic [31:0] epc;
      logic [4:0]  cause;
      logic        exl;
      logic        dfault;
   } exp_t;

   exp_t sb[$];

   // {RegDst,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp}
   localparam logic [8:0] C_NOP  = 9'b000000000;
   localparam logic [8:0] C_R    = 9'b100000110;
   localparam logic [8:0] C_BR   = 9'b010000001;
   localparam logic [8:0] C_LW   = 9'b001101100;
   localparam logic [8:0] C_SW   = 9'b000011000;
   localparam logic [8:0] C_ADDI = 9'b000001100;
   localparam logic [8:0] C_LOG  = 9'b000001111;

   exception_control_unit dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .id_pc        (id_pc),
      .ex_pc        (ex_pc),
      .overflow     (overflow),
      .stall        (stall),
      .ex_RegDst    (ex_RegDst),
      .ex_Branch    (ex_Branch),
      .ex_MemRead   (ex_MemRead),
      .ex_MemtoReg  (ex_MemtoReg),
      .ex_MemWrite  (ex_MemWrite),
      .ex_ALUSrc    (ex_ALUSrc),
      .ex_RegWrite  (ex_RegWrite),
      .ex_ALUOp     (ex_ALUOp),
      .pc_sel       (pc_sel),
      .if_flush     (if_flush),
      .id_flush     (id_flush),
      .ex_flush     (ex_flush),
      .epc          (epc),
      .cause        (cause),
      .exl          (exl),
      .double_fault (double_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [8:0] c, input logic [1:0] ps,
                               input logic fl, input logic exf,
                               input logic [31:0] e, input logic [4:0] ca,
                               input logic x, input logic df);
      exp_t r;
      r.ctrl = c; r.pc_sel = ps; r.if_flush = fl; r.id_flush = fl;
      r.ex_flush = exf; r.epc = e; r.cause = ca; r.exl = x; r.dfault = df;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue its expected post-edge outputs, then compare
   task automatic step(input string tag, input logic r, input logic [5:0] op,
                       input logic [31:0] ipc, input logic ovf, input logic [31:0] epc_in,
                       input logic stl, input exp_t e);
      exp_t x;
      rst = r; opcode = op; id_pc = ipc; overflow = ovf; ex_pc = epc_in; stall = stl;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         x = sb.pop_front();
         chk({tag, ".ctrl"}, {23'd0, ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg,
                              ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_ALUOp}, {23'd0, x.ctrl});
         chk({tag, ".pc_sel"},   {30'd0, pc_sel},   {30'd0, x.pc_sel});
         chk({tag, ".if_flush"}, {31'd0, if_flush}, {31'd0, x.if_flush});
         chk({tag, ".id_flush"}, {31'd0, id_flush}, {31'd0, x.id_flush});
         chk({tag, ".ex_flush"}, {31'd0, ex_flush}, {31'd0, x.ex_flush});
         chk({tag, ".epc"},      epc,               x.epc);
         chk({tag, ".cause"},    {27'd0, cause},    {27'd0, x.cause});
         chk({tag, ".exl"},      {31'd0, exl},      {31'd0, x.exl});
         chk({tag, ".dfault"},   {31'd0, double_fault}, {31'd0, x.dfault});
      end
   endtask

   initial begin
      rst = 1'b1; opcode = 6'd35; id_pc = 32'd0; ex_pc = 32'd0;
      overflow = 1'b0; stall = 1'b0;

      // reset and basic decode
      step("rst0",   1'b1, 6'd35, 32'h00, 1'b0, 32'h00, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("rst1",   1'b1, 6'd35, 32'h00, 1'b0, 32'h00, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("lw",     1'b0, 6'd35, 32'h04, 1'b0, 32'h00, 1'b0, mk(C_LW,  2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("stall",  1'b0, 6'd35, 32'h08, 1'b0, 32'h00, 1'b1, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("rtype",  1'b0, 6'd0,  32'h08, 1'b0, 32'h00, 1'b0, mk(C_R,   2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("beq",    1'b0, 6'd4,  32'h0C, 1'b0, 32'h00, 1'b0, mk(C_BR,  2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("bne",    1'b0, 6'd5,  32'h10, 1'b0, 32'h00, 1'b0, mk(C_BR,  2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("sw",     1'b0, 6'd43, 32'h14, 1'b0, 32'h00, 1'b0, mk(C_SW,  2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("addi",   1'b0, 6'd8,  32'h18, 1'b0, 32'h00, 1'b0, mk(C_ADDI,2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("andi",   1'b0, 6'd12, 32'h1C, 1'b0, 32'h00, 1'b0, mk(C_LOG, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));
      step("ori",    1'b0, 6'd13, 32'h20, 1'b0, 32'h00, 1'b0, mk(C_LOG, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0));

      // invalid opcode trap, then back to IDLE
      step("inv_trap", 1'b0, 6'd63, 32'h40, 1'b0, 32'h3C, 1'b0, mk(C_NOP, 2'b01, 1'b1, 1'b0, 32'h40, 5'd10, 1'b1, 1'b0));
      step("inv_idle", 1'b0, 6'd0,  32'h44, 1'b0, 32'h40, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h40, 5'd10, 1'b1, 1'b0));

      // overflow while in handler: squash, double fault, no redirect
      step("dbl",      1'b0, 6'd0, 32'h48, 1'b1, 32'h3C, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b1, 32'h40, 5'd10, 1'b1, 1'b1));
      step("dbl_end",  1'b0, 6'd0, 32'h4C, 1'b0, 32'h48, 1'b0, mk(C_R,   2'b00, 1'b0, 1'b0, 32'h40, 5'd10, 1'b1, 1'b0));

      // ERET with exl = 1
      step("eret",     1'b0, 6'd16, 32'h50, 1'b0, 32'h4C, 1'b0, mk(C_NOP, 2'b10, 1'b1, 1'b0, 32'h40, 5'd10, 1'b1, 1'b0));
      step("eret_end", 1'b0, 6'd0,  32'h40, 1'b0, 32'h50, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h40, 5'd10, 1'b0, 1'b0));
      step("post_ret", 1'b0, 6'd0,  32'h44, 1'b0, 32'h40, 1'b0, mk(C_R,   2'b00, 1'b0, 1'b0, 32'h40, 5'd10, 1'b0, 1'b0));

      // overflow + invalid + stall together: overflow wins
      step("ovf_trap", 1'b0, 6'd63, 32'h40, 1'b1, 32'h3C, 1'b1, mk(C_NOP, 2'b01, 1'b1, 1'b1, 32'h3C, 5'd12, 1'b1, 1'b0));
      step("trap_ovf", 1'b0, 6'd35, 32'h44, 1'b1, 32'h40, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b1, 32'h3C, 5'd12, 1'b1, 1'b0));
      step("eret2",    1'b0, 6'd16, 32'h180, 1'b0, 32'h44, 1'b0, mk(C_NOP, 2'b10, 1'b1, 1'b0, 32'h3C, 5'd12, 1'b1, 1'b0));
      step("eret2_end",1'b0, 6'd0,  32'h3C, 1'b0, 32'h180, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h3C, 5'd12, 1'b0, 1'b0));

      // ERET with exl = 0 is an invalid instruction
      step("eret_inv", 1'b0, 6'd16, 32'h80, 1'b0, 32'h3C, 1'b0, mk(C_NOP, 2'b01, 1'b1, 1'b0, 32'h80, 5'd10, 1'b1, 1'b0));
      step("ei_idle",  1'b0, 6'd0,  32'h180, 1'b0, 32'h80, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h80, 5'd10, 1'b1, 1'b0));
      step("eret3",    1'b0, 6'd16, 32'h184, 1'b0, 32'h180, 1'b0, mk(C_NOP, 2'b10, 1'b1, 1'b0, 32'h80, 5'd10, 1'b1, 1'b0));
      step("eret3_end",1'b0, 6'd0,  32'h80, 1'b0, 32'h184, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h80, 5'd10, 1'b0, 1'b0));

      // reset during TRAP aborts to IDLE with everything cleared
      step("trap4",    1'b0, 6'd63, 32'h90, 1'b0, 32'h80, 1'b0, mk(C_NOP, 2'b01, 1'b1, 1'b0, 32'h90, 5'd10, 1'b1, 1'b0));
      step("rst_trap", 1'b1, 6'd0,  32'h94, 1'b0, 32'h90, 1'b0, mk(C_NOP, 2'b00, 1'b0, 1'b0, 32'h0,  5'd0,  1'b0, 1'b0));
      step("after_rst",1'b0, 6'd0,  32'h00, 1'b0, 32'h00, 1'b0, mk(C_R,   2'b00, 1'b0, 1'b0, 32'h0,  5'd0,  1'b0, 1'b0));

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exception_control_unit.md
Name: exception_control_unit

Overview:
- Second-generation main control for the 5-stage MIPS pipeline. It decodes the ID-stage opcode and registers the control bundle into the ID/EX boundary, inserting bubbles on stall or flush.
- A precise-exception FSM handles invalid opcodes (ID stage) and arithmetic overflow (EX stage). It latches EPC and Cause, flushes IF/ID/EX and redirects the PC to the handler.
- It supports ERET return and an EXL (in-handler) mask.
- It sits between the instruction decoder, the hazard unit and the PC-select mux.

Parameters:
- PC_WIDTH, 32, width of PC, EPC and handler address.
- HANDLER_ADDR, 32'h0000_0180, exception vector loaded into the PC on trap.
- CAUSE_RI, 5'd10, ExcCode for reserved/invalid instruction.
- CAUSE_OV, 5'd12, ExcCode for arithmetic overflow.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  ID-stage instruction[31:26].
- id_pc  in  PC_WIDTH  PC of the instruction in ID.
- ex_pc  in  PC_WIDTH  PC of the instruction in EX.
- overflow  in  1  ALU overflow for the instruction in EX (valid only for add/addi/sub).
- stall  in  1  load-use stall request from the hazard unit.
- ex_RegDst, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  out  1 each  registered ID/EX control.
- ex_ALUOp  out  2  registered ALU op class.
- pc_sel  out  2  00 = sequential/branch, 01 = HANDLER_ADDR, 10 = epc.
- if_flush, id_flush  out  1  registered flush of the IF/ID and ID/EX inputs.
- ex_flush  out  1  combinational kill of the EX/MEM write-enables.
- epc  out  PC_WIDTH  exception PC.
- cause  out  5  last ExcCode.
- exl  out  1  exception level (in handler).
- double_fault  out  1  one-cycle pulse when an exception is taken while exl = 1.

Behaviour:
- Decode (combinational, ID stage):
  - 0 = R-type: RegDst, RegWrite, ALUOp = 10.
  - 4 = beq and 5 = bne: Branch, ALUOp = 01.
  - 35 = lw: ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp = 00.
  - 43 = sw: ALUSrc, MemWrite, ALUOp = 00.
  - 8 = addi: ALUSrc, RegWrite, ALUOp = 00.
  - 12 = andi and 13 = ori: ALUSrc, RegWrite, ALUOp = 11.
  - 16 = ERET: all controls 0.
  - Any other opcode: all controls 0, invalid = 1.
  - ERET while exl = 0 is also invalid.
- ID/EX register, each clock edge, in priority order:
  - rst: load all zeros.
  - State TRAP or RETURN, or exception detected this cycle: load zeros (bubble).
  - stall: load zeros.
  - Otherwise: load the decoded bundle.
- Detection in cycle N, state IDLE:
  - ovf = overflow; inv = invalid.
  - Overflow has priority over inv because EX is older.
  - ex_flush = overflow, combinational, in cycle N irrespective of state or exl, so the offending instruction never writes back.
- FSM states IDLE, TRAP, RETURN; reset state IDLE.
- IDLE transitions:
  - Exception and exl = 0: go to TRAP. At the edge latch epc = ex_pc (ovf) or id_pc (inv), cause = CAUSE_OV or CAUSE_RI, exl = 1.
  - Exception and exl = 1: stay in IDLE. epc and cause are unchanged, no redirect, double_fault pulses in cycle N+1. The offending instruction is still squashed: ex_flush for ovf, bubble for inv.
  - ERET in ID and exl = 1: go to RETURN.
- TRAP (exactly 1 cycle, N+1): pc_sel = 01, if_flush = 1, id_flush = 1, then IDLE.
- RETURN (exactly 1 cycle): pc_sel = 10, if_flush = 1, id_flush = 1, exl cleared at exit, then IDLE. epc is unchanged.
- Inputs in TRAP/RETURN: stall and new opcode are ignored. Overflow still drives ex_flush but is not taken as an exception, since the instruction is a wrong-path squash.
- Simultaneous stall and exception: exception wins; the bubble is inserted anyway.
- Reset values: all outputs 0, epc = 0, cause = 0, exl = 0, state = IDLE. rst mid-TRAP/RETURN aborts it to IDLE next edge.

Decomposition:
- Shared package, included by this block, the ALU control and the hazard unit:
  - opcode localparams OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_ERET;
  - ALUOp codes;
  - pc_sel encodings;
  - ExcCode values;
  - FSM state encoding.
- Sub-module main_decoder: the purely combinational opcode-to-bundle + invalid decode, reused by the ID-stage debug monitor.

Test Plan:
- rst = 1 for 2 cycles, opcode = 35 → all outputs 0. After release, next edge ex_MemRead = ex_MemtoReg = ex_RegWrite = ex_ALUSrc = 1, ex_ALUOp = 00.
- opcode = 35 with stall = 1 for 1 cycle → ID/EX outputs all 0 that edge; opcode = 0 next cycle, stall = 0 → ex_RegDst = 1, ex_ALUOp = 10.
- opcode = 63, id_pc = 0x40 → next cycle pc_sel = 01, if_flush = id_flush = 1, epc = 0x40, cause = 10, exl = 1; then IDLE with pc_sel = 00.
- Same cycle: overflow = 1 with ex_pc = 0x3C and opcode = 63 with id_pc = 0x40 → ex_flush = 1 immediately; epc = 0x3C, cause = 12.
- exl = 1, overflow = 1 → ex_flush = 1, double_fault pulses once, epc/cause unchanged, pc_sel stays 00.
- exl = 1, opcode = 16 → next cycle pc_sel = 10 with epc intact, if_flush = id_flush = 1, exl = 0 after. opcode = 16 with exl = 0 → trap with cause = 10.
